// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional build macro: IF_FAULT_EN adds a per-entry fetch fault tag.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef IF_FAULT_EN
    logic        fault;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Prefetch FIFO between the fetch PC and decode. Flush clears pointers and
// occupancy only; stale storage is harmless because id_valid masks it.
// Optional build macro: IF_FAULT_EN (widens fetch_entry_t by the fault bit).
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Entry storage; cleared on reset so the idle outputs are defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives imem_addr, buffers
// fetched words in a prefetch FIFO and hands {pc, instr} to decode.
// Optional build macro: IF_FAULT_EN adds the id_fault port and tags
// misaligned / out-of-range fetches (their instruction is replaced by a NOP).
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 2,
  parameter int          MEMORY_SIZE = 8196
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef IF_FAULT_EN
  ,
  output logic        id_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MEMORY_SIZE < 4) begin : g_bad_params
    $error("if_stage: FIFO_DEPTH must be a power of two >= 2 and MEMORY_SIZE >= 4");
  end

  logic [31:0]   fetch_pc;
  logic          push;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_full_unused;
  logic          fifo_empty;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  assign imem_addr = fetch_pc;
  assign id_valid  = !fifo_empty;
  assign pop       = id_valid && id_ready;
  // A full FIFO may still accept when decode drains the head this cycle.
  assign push      = !redirect_valid && ((fifo_count < CW'(FIFO_DEPTH)) || pop);

`ifdef IF_FAULT_EN
  logic [32:0] last_byte;
  logic        fault_now;

  // 33-bit sum so a PC near 2^32 cannot wrap back into range.
  assign last_byte = {1'b0, fetch_pc} + 33'd3;
  assign fault_now = (fetch_pc[1:0] != 2'b00) || (last_byte >= 33'(MEMORY_SIZE));
`endif

  // Build the entry written on push; faulted fetches carry a NOP.
  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = fetch_pc;
    wr_entry.instr = imem_instr;
`ifdef IF_FAULT_EN
    wr_entry.fault = fault_now;
    if (fault_now) wr_entry.instr = NOP_INSTR;
`endif
  end

  // Fetch PC: redirect wins, otherwise advance by one word per push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (wr_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full_unused),
    .empty (fifo_empty)
  );

  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_pc_plus4 = head.pc + 32'd4;
`ifdef IF_FAULT_EN
  assign id_fault    = head.fault;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage: owns the fetch PC, drives the combinational instruction memory address, and captures returned words into a small prefetch FIFO. Presents {pc, instr} to the decode stage over a valid/ready handshake. Handles decode backpressure and control-flow redirects (branch/jump/trap) by flushing and re-steering.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, at least 2.
- MEMORY_SIZE, 8196, instruction memory size in bytes; used only by the fault check.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  32  byte address to instruction memory; always equals fetch_pc
- imem_instr  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  flush and re-steer request
- redirect_pc  in  32  new fetch PC when redirect_valid=1
- id_valid  out  1  FIFO head valid
- id_ready  in  1  decode accepts head
- id_instr  out  32  head instruction
- id_pc  out  32  head PC
- id_pc_plus4  out  32  id_pc+4, modulo 2^32
- id_fault  out  1  head fault tag; present only with IF_FAULT_EN

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, count=0, rd/wr pointers=0, all FIFO storage=0. Outputs: id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4, id_fault=0.
- pop = id_valid & id_ready.
- push = !redirect_valid & (count<FIFO_DEPTH | pop). On push, store {fetch_pc, imem_instr}, then fetch_pc += 4 (wraps at 2^32).
- Full with simultaneous pop: push is allowed; count stays at FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.
- id_* outputs are read from storage at rd_ptr; id_valid = (count!=0). No combinational path from imem_instr to the id_* outputs.
- Redirect in cycle N:
  - Next edge: count=0, pointers=0, fetch_pc=redirect_pc, no push.
  - A pop in cycle N still counts as consumed by decode.
  - Cycle N+1: id_valid=0, and redirect_pc is pushed if no further redirect arrives.
  - Cycle N+2: id_valid=1, id_pc=redirect_pc.
  - Back-to-back redirects: the last one wins.
- Steady state: one instruction per cycle. First id_valid occurs one cycle after reset release, with id_pc=RESET_PC.
- Empty FIFO: id_valid=0; other id_* outputs hold the stale slot value and carry no meaning.
- Misaligned redirect_pc is loaded unchanged. Alignment is checked only under IF_FAULT_EN.

Optional Feature:
IF_FAULT_EN
- With: each pushed entry is tagged fault=1 if fetch_pc[1:0]!=0 or fetch_pc+3 >= MEMORY_SIZE. For faulted entries, the stored instr is forced to NOP 32'h0000_0013. The tag appears on id_fault.
- Without: port id_fault, the fault logic and the fault storage bit do not exist. Instruction words are stored unmodified.

Decomposition:
- Package if_pkg:
  - NOP_INSTR constant (32'h0000_0013).
  - fetch_entry_t packed struct {pc[31:0], instr[31:0], fault}, with fault only under IF_FAULT_EN.
- Sub-module fetch_fifo: parameterised by depth, element type fetch_entry_t. Ports: push, pop, flush, din, dout, count, full, empty. Same clock and reset as if_stage.
- if_stage holds the PC register, push/pop/redirect control and the fault check.

Test Plan:
- Reset, then id_ready=1, memory word at address k equal to k: id_pc=0,4,8,12 on consecutive cycles starting one cycle after reset release; id_instr=id_pc; id_pc_plus4=id_pc+4.
- id_ready=0 for 6 cycles: count saturates at 2; imem_addr holds 8; heads 0 then 4 are delivered once ready returns, with no loss or duplication.
- Redirect to 0x100 while the FIFO is full: the next cycle has id_valid=0; the following cycle has id_valid=1 and id_pc=0x100; entries 0 and 4 never appear after the redirect.
- Redirect to 0x40 in the same cycle as a pop of pc=0x8: 0x8 counts as consumed once; the next delivered PC is 0x40, followed by 0x44.
- rst_n asserted mid-stream: id_valid drops immediately (asynchronously); after release, fetch restarts at RESET_PC.
- IF_FAULT_EN, redirect to 0x102, then to 8196-2: id_fault=1 and id_instr=0x0000_0013 for both; an aligned in-range PC gives id_fault=0.
